// File: rtl/bus_demux_n.sv
// ---------------------------------------------------------------------------
// bus_demux_n
//
// Splits the core's valid/ready memory interface across NUM_SLV slave ports
// using a table-driven address map (base/mask per window). Slave requests are
// registered, each access is guarded by a wait-cycle watchdog, and unmapped or
// timed-out accesses are completed with an error response, an interrupt pulse,
// a latched error address and a saturating error counter.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   core_valid_i/addr/wdata/wstrb   core request (wstrb == 0 means read)
//   core_rdata_o, core_ready_o      core response (ready is a 1-cycle pulse)
//   slv_valid_o                     one-hot request valid, one bit per slave
//   slv_addr_o/wdata_o/wstrb_o      registered request fields, shared
//   slv_rdata_i, slv_ready_i        per-slave response, slave k at [32k+:32]
//   err_irq_o                       1-cycle pulse with every error completion
//   err_addr_o                      address of the most recent errored access
//   err_cnt_o                       saturating error count
// ---------------------------------------------------------------------------
module bus_demux_n #(
    parameter int                    NUM_SLV   = 4,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE  = {NUM_SLV{32'h0}},
    parameter logic [NUM_SLV*32-1:0] SLV_MASK  = {NUM_SLV{32'hFFFF_0000}},
    parameter int                    TIMEOUT   = 255,
    parameter logic [31:0]           ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  core_valid_i,
    input  logic [31:0]           core_addr_i,
    input  logic [31:0]           core_wdata_i,
    input  logic [3:0]            core_wstrb_i,
    output logic [31:0]           core_rdata_o,
    output logic                  core_ready_o,
    output logic [NUM_SLV-1:0]    slv_valid_o,
    output logic [31:0]           slv_addr_o,
    output logic [31:0]           slv_wdata_o,
    output logic [3:0]            slv_wstrb_o,
    input  logic [NUM_SLV*32-1:0] slv_rdata_i,
    input  logic [NUM_SLV-1:0]    slv_ready_i,
    output logic                  err_irq_o,
    output logic [31:0]           err_addr_o,
    output logic [7:0]            err_cnt_o
);

    // Watchdog only ever counts 0..TIMEOUT while enabled.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_SLV-1:0]  slv_valid_q, slv_valid_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                core_ready_q, core_ready_d;
    logic                err_irq_q, err_irq_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [WD_W-1:0]     wd_q, wd_d;

    // ---------------------------------------------------------------------
    // Address decode. prior[k] says a lower-indexed window already matched,
    // so grant is the one-hot of the lowest matching window.
    // ---------------------------------------------------------------------
    logic [NUM_SLV-1:0] hit;
    logic [NUM_SLV-1:0] grant;
    logic [NUM_SLV:0]   prior;
    logic [31:0]        lane [NUM_SLV];

    assign prior[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign hit[gi]       = ((core_addr_i & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32]);
            assign prior[gi + 1] = prior[gi] | hit[gi];
            assign grant[gi]     = hit[gi] & ~prior[gi];
            // Only the slave currently being accessed contributes read data.
            assign lane[gi]      = slv_rdata_i[gi*32 +: 32] & {32{slv_valid_q[gi]}};
        end
    endgenerate

    logic        mapped;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    assign mapped    = prior[NUM_SLV];
    // Ready from any slave other than the selected one is masked off here.
    assign sel_ready = |(slv_ready_i & slv_valid_q);

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            sel_rdata = sel_rdata | lane[k];
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        slv_valid_d  = slv_valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        core_ready_d = 1'b0;
        err_irq_d    = 1'b0;
        err_addr_d   = err_addr_q;
        err_cnt_d    = err_cnt_q;
        wd_d         = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (core_valid_i) begin
                    addr_d  = core_addr_i;
                    wdata_d = core_wdata_i;
                    wstrb_d = core_wstrb_i;
                    if (mapped) begin
                        slv_valid_d = grant;
                        wd_d        = '0;
                        state_d     = ST_ACCESS;
                    end else begin
                        state_d     = ST_ERR;
                    end
                end
            end

            ST_ACCESS: begin
                // A ready arriving on the timeout cycle still wins.
                if (sel_ready) begin
                    rdata_d      = sel_rdata;
                    slv_valid_d  = '0;
                    core_ready_d = 1'b1;
                    state_d      = ST_RESP;
                end else if ((TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT))) begin
                    slv_valid_d  = '0;
                    state_d      = ST_ERR;
                end else begin
                    wd_d         = wd_q + 1'b1;
                end
            end

            // Prepares the error response; it becomes visible in ST_RESP.
            ST_ERR: begin
                rdata_d      = ERR_RDATA;
                core_ready_d = 1'b1;
                err_irq_d    = 1'b1;
                err_addr_d   = addr_q;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d      = ST_RESP;
            end

            // Response cycle: core_ready_o is high here. The core still holds
            // its request this cycle, so the request is not re-sampled.
            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            slv_valid_q  <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            core_ready_q <= 1'b0;
            err_irq_q    <= 1'b0;
            err_addr_q   <= '0;
            err_cnt_q    <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            slv_valid_q  <= slv_valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            core_ready_q <= core_ready_d;
            err_irq_q    <= err_irq_d;
            err_addr_q   <= err_addr_d;
            err_cnt_q    <= err_cnt_d;
            wd_q         <= wd_d;
        end
    end

    assign core_rdata_o = rdata_q;
    assign core_ready_o = core_ready_q;
    assign slv_valid_o  = slv_valid_q;
    assign slv_addr_o   = addr_q;
    assign slv_wdata_o  = wdata_q;
    assign slv_wstrb_o  = wstrb_q;
    assign err_irq_o    = err_irq_q;
    assign err_addr_o   = err_addr_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
